// File: rtl/stack_glyph_renderer_if.sv
// Signal bundle between the glyph renderer and its stack, font ROM and framebuffer.
// The master modport is the renderer side; the slave modport is the surrounding system.
interface stack_glyph_renderer_if #(
    parameter int unsigned CHAR_ID_WIDTH   = 8,
    parameter int unsigned X_WIDTH         = 9,
    parameter int unsigned Y_WIDTH         = 9,
    parameter int unsigned GLYPH_W         = 8,
    parameter int unsigned FONT_ADDR_WIDTH = 12
);
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       pop;
    logic [CHAR_ID_WIDTH-1:0]   character_id;
    logic [X_WIDTH-1:0]         x;
    logic [Y_WIDTH-1:0]         y;
    logic                       empty;
    logic [FONT_ADDR_WIDTH-1:0] font_addr;
    logic [GLYPH_W-1:0]         font_data;
    logic                       fb_we;
    logic                       fb_ready;
    logic [X_WIDTH-1:0]         fb_x;
    logic [Y_WIDTH-1:0]         fb_y;
    logic                       fb_data;

    modport master (
        input  start, character_id, x, y, empty, font_data, fb_ready,
        output busy, done, pop, font_addr, fb_we, fb_x, fb_y, fb_data
    );

    modport slave (
        output start, character_id, x, y, empty, font_data, fb_ready,
        input  busy, done, pop, font_addr, fb_we, fb_x, fb_y, fb_data
    );
endinterface

// File: rtl/stack_glyph_renderer.sv
// Drains the character stack and renders each glyph pixel by pixel into the framebuffer,
// clipping pixels that fall outside the visible screen.
module stack_glyph_renderer #(
    parameter int unsigned CHAR_ID_WIDTH   = 8,
    parameter int unsigned X_WIDTH         = 9,
    parameter int unsigned Y_WIDTH         = 9,
    parameter int unsigned GLYPH_W         = 8,
    parameter int unsigned GLYPH_H         = 16,
    parameter int unsigned SCREEN_W        = 320,
    parameter int unsigned SCREEN_H        = 240,
    parameter int unsigned FONT_ADDR_WIDTH = 12
) (
    input  logic                    clock,
    input  logic                    reset_n,
    stack_glyph_renderer_if.master  bus
);
    localparam int unsigned ColW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int unsigned RowW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

    typedef enum logic [2:0] {
        StIdle, StPop, StLatch, StRomReq, StRomWait, StDraw, StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [CHAR_ID_WIDTH-1:0] id_q, id_d;
    logic [X_WIDTH-1:0]       x_q, x_d;
    logic [Y_WIDTH-1:0]       y_q, y_d;
    logic [RowW-1:0]          row_q, row_d;
    logic [ColW-1:0]          col_q, col_d;
    logic [GLYPH_W-1:0]       bits_q, bits_d;

    // One extra bit so glyphs near the right/bottom edge clip instead of wrapping.
    logic [X_WIDTH:0]   px;
    logic [Y_WIDTH:0]   py;
    logic               in_bounds;
    logic               col_last;
    logic               row_last;
    logic [GLYPH_W-1:0] bits_shifted;

    assign px        = {1'b0, x_q} + (X_WIDTH + 1)'(col_q);
    assign py        = {1'b0, y_q} + (Y_WIDTH + 1)'(row_q);
    assign in_bounds = (px < (X_WIDTH + 1)'(SCREEN_W)) && (py < (Y_WIDTH + 1)'(SCREEN_H));
    assign col_last  = (col_q == ColW'(GLYPH_W - 1));
    assign row_last  = (row_q == RowW'(GLYPH_H - 1));

    assign bits_shifted  = bits_q << col_q;
    assign bus.fb_data   = bits_shifted[GLYPH_W-1];
    assign bus.fb_x      = px[X_WIDTH-1:0];
    assign bus.fb_y      = py[Y_WIDTH-1:0];
    assign bus.font_addr = FONT_ADDR_WIDTH'(id_q) * FONT_ADDR_WIDTH'(GLYPH_H)
                         + FONT_ADDR_WIDTH'(row_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            col_q   <= col_d;
            bits_q  <= bits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        x_d        = x_q;
        y_d        = y_q;
        row_d      = row_q;
        col_d      = col_q;
        bits_d     = bits_q;
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.pop    = (state_q == StPop);
        bus.fb_we  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = bus.empty ? StDone : StPop;
                end
            end
            StPop:   state_d = StLatch;
            StLatch: begin
                id_d    = bus.character_id;
                x_d     = bus.x;
                y_d     = bus.y;
                row_d   = '0;
                state_d = StRomReq;
            end
            StRomReq:  state_d = StRomWait;
            StRomWait: begin
                bits_d  = bus.font_data;
                col_d   = '0;
                state_d = StDraw;
            end
            StDraw: begin
                bus.fb_we = in_bounds;
                // Clipped pixels take one cycle; visible ones wait for the framebuffer.
                if (!in_bounds || bus.fb_ready) begin
                    if (!col_last) begin
                        col_d = col_q + ColW'(1);
                    end else if (!row_last) begin
                        row_d   = row_q + RowW'(1);
                        state_d = StRomReq;
                    end else begin
                        state_d = bus.empty ? StDone : StPop;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_stack_glyph_renderer.sv
// Scoreboard bench for stack_glyph_renderer: stack and font ROM models drive the DUT,
// expected pixel writes are queued at stimulus time and compared by a monitor process.
module tb_stack_glyph_renderer;
    logic clock;
    logic reset_n;

    stack_glyph_renderer_if bus ();

    stack_glyph_renderer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic       d;
    } pix_t;

    typedef struct packed {
        logic [7:0] id;
        logic [8:0] x;
        logic [8:0] y;
    } ent_t;

    pix_t exp_q[$];
    pix_t log_q[$];
    ent_t stk[$];

    int nchk       = 0;
    int errs       = 0;
    int cyc        = 0;
    int rom_mode   = 0;
    int ready_mode = 0;
    int pop_cnt    = 0;
    int done_cnt   = 0;
    int we_cnt     = 0;
    int done_cyc   = 0;
    int start_cyc  = 0;

    function automatic logic [7:0] rom_byte(logic [11:0] a);
        if (rom_mode == 0) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    task automatic chk(string name, int act, int expv);
        nchk++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic expect_glyph(ent_t e);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                int px;
                int py;
                int a;
                logic [7:0] b;
                px = int'(e.x) + c;
                py = int'(e.y) + r;
                a  = int'(e.id) * 16 + r;
                b  = rom_byte(a[11:0]);
                if (px < 320 && py < 240) begin
                    exp_q.push_back(pix_t'{x: px[8:0], y: py[8:0], d: b[7-c]});
                end
            end
        end
    endtask

    task automatic do_start();
        @(posedge clock);
        #1;
        bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string name, int lat);
        int t;
        int d0;
        t  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        chk({name, "_done_seen"}, done_cnt - d0, 1);
        if (lat > 0 && done_cnt != d0) chk({name, "_latency"}, done_cyc - start_cyc + 1, lat);
        repeat (3) @(negedge clock);
        chk({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Font ROM: address sampled on one edge, data presented after the next.
    initial begin : rom_model
        logic [11:0] ra;
        bus.font_data = '0;
        forever begin
            @(negedge clock);
            ra = bus.font_addr;
            @(posedge clock);
            #1;
            bus.font_data = rom_byte(ra);
        end
    end

    // Stack: a pop seen in one cycle makes the top entry visible in the next.
    initial begin : stack_model
        logic p;
        ent_t e;
        bus.empty        = 1'b1;
        bus.character_id = '0;
        bus.x            = '0;
        bus.y            = '0;
        forever begin
            @(negedge clock);
            p = bus.pop && reset_n;
            if (p) begin
                pop_cnt++;
                chk("pop_while_empty", (stk.size() == 0) ? 1 : 0, 0);
            end
            @(posedge clock);
            #1;
            if (p && stk.size() > 0) begin
                e = stk.pop_back();
                bus.character_id = e.id;
                bus.x            = e.x;
                bus.y            = e.y;
            end
            bus.empty = (stk.size() == 0);
        end
    end

    // fb_ready follows 1,0,0,1,... when ready_mode is set, otherwise stays high.
    initial begin : ready_driver
        int k;
        k = 0;
        bus.fb_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode != 0) begin
                bus.fb_ready = ((k % 4) == 0) || ((k % 4) == 3);
                k++;
            end else begin
                bus.fb_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic hold;
        pix_t hp;
        pix_t cur;
        pix_t e;
        hold = 1'b0;
        hp   = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                hold = 1'b0;
            end else begin
                cur = pix_t'{x: bus.fb_x, y: bus.fb_y, d: bus.fb_data};
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (hold) begin
                    chk("hold_we", int'(bus.fb_we), 1);
                    chk("hold_x", int'(cur.x), int'(hp.x));
                    chk("hold_y", int'(cur.y), int'(hp.y));
                    chk("hold_data", int'(cur.d), int'(hp.d));
                end
                if (bus.fb_we) begin
                    we_cnt++;
                    if (bus.fb_ready) begin
                        chk("bound_x", (int'(cur.x) < 320) ? 1 : 0, 1);
                        chk("bound_y", (int'(cur.y) < 240) ? 1 : 0, 1);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pix_x", int'(cur.x), int'(e.x));
                            chk("pix_y", int'(cur.y), int'(e.y));
                            chk("pix_data", int'(cur.d), int'(e.d));
                        end
                        log_q.push_back(cur);
                    end
                end
                hold = bus.fb_we && !bus.fb_ready;
                hp   = cur;
            end
        end
    end

    initial begin : main
        int p0;
        int w0;
        int t;
        ent_t e1;
        ent_t e2;
        bus.start = 1'b0;
        reset_n   = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pop", int'(bus.pop), 0);
        chk("rst_fb_we", int'(bus.fb_we), 0);
        chk("rst_font_addr", int'(bus.font_addr), 0);
        chk("rst_fb_x", int'(bus.fb_x), 0);
        chk("rst_fb_y", int'(bus.fb_y), 0);
        chk("rst_fb_data", int'(bus.fb_data), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Empty stack: done two cycles after start, nothing popped or written.
        p0 = pop_cnt;
        w0 = we_cnt;
        do_start();
        wait_done("empty", 2);
        chk("empty_pops", pop_cnt - p0, 0);
        chk("empty_writes", we_cnt - w0, 0);

        // Single glyph with every row 0xA5.
        rom_mode = 0;
        stk.push_back(ent_t'{id: 8'h41, x: 9'd10, y: 9'd20});
        expect_glyph(ent_t'{id: 8'h41, x: 9'd10, y: 9'd20});
        log_q.delete();
        p0 = pop_cnt;
        repeat (2) @(negedge clock);
        do_start();
        wait_done("one", 164);
        chk("one_pops", pop_cnt - p0, 1);
        chk("one_writes", log_q.size(), 128);
        if (log_q.size() == 128) begin
            chk("one_first_x", int'(log_q[0].x), 10);
            chk("one_first_y", int'(log_q[0].y), 20);
            chk("one_first_d", int'(log_q[0].d), 1);
            chk("one_second_x", int'(log_q[1].x), 11);
            chk("one_second_d", int'(log_q[1].d), 0);
            chk("one_last_x", int'(log_q[127].x), 17);
            chk("one_last_y", int'(log_q[127].y), 35);
        end
        chk("one_exp_left", exp_q.size(), 0);

        // LIFO drain of three entries.
        rom_mode = 1;
        stk.push_back(ent_t'{id: 8'h41, x: 9'd0, y: 9'd0});
        stk.push_back(ent_t'{id: 8'h42, x: 9'd100, y: 9'd50});
        stk.push_back(ent_t'{id: 8'h43, x: 9'd200, y: 9'd100});
        expect_glyph(ent_t'{id: 8'h43, x: 9'd200, y: 9'd100});
        expect_glyph(ent_t'{id: 8'h42, x: 9'd100, y: 9'd50});
        expect_glyph(ent_t'{id: 8'h41, x: 9'd0, y: 9'd0});
        log_q.delete();
        p0 = pop_cnt;
        repeat (2) @(negedge clock);
        do_start();
        wait_done("lifo", 488);
        chk("lifo_pops", pop_cnt - p0, 3);
        chk("lifo_writes", log_q.size(), 384);
        if (log_q.size() > 0) chk("lifo_first_x", int'(log_q[0].x), 200);
        chk("lifo_exp_left", exp_q.size(), 0);

        // Clipping: partial glyph at the corner, and one fully past the right edge.
        stk.push_back(ent_t'{id: 8'h10, x: 9'd509, y: 9'd5});
        stk.push_back(ent_t'{id: 8'h22, x: 9'd316, y: 9'd230});
        expect_glyph(ent_t'{id: 8'h22, x: 9'd316, y: 9'd230});
        expect_glyph(ent_t'{id: 8'h10, x: 9'd509, y: 9'd5});
        log_q.delete();
        w0 = we_cnt;
        repeat (2) @(negedge clock);
        do_start();
        wait_done("clip", 326);
        chk("clip_writes", log_q.size(), 40);
        chk("clip_we_cycles", we_cnt - w0, 40);
        chk("clip_exp_left", exp_q.size(), 0);

        // Backpressure: outputs held while stalled, no pixel lost or repeated.
        ready_mode = 1;
        stk.push_back(ent_t'{id: 8'h30, x: 9'd40, y: 9'd60});
        expect_glyph(ent_t'{id: 8'h30, x: 9'd40, y: 9'd60});
        log_q.delete();
        repeat (2) @(negedge clock);
        do_start();
        wait_done("stall", 0);
        chk("stall_writes", log_q.size(), 128);
        chk("stall_exp_left", exp_q.size(), 0);
        ready_mode = 0;
        repeat (2) @(negedge clock);

        // Reset in the middle of a glyph, then resume with the remaining entry.
        e1 = ent_t'{id: 8'h51, x: 9'd80, y: 9'd90};
        e2 = ent_t'{id: 8'h52, x: 9'd120, y: 9'd130};
        stk.push_back(e1);
        stk.push_back(e2);
        expect_glyph(e2);
        log_q.delete();
        repeat (2) @(negedge clock);
        do_start();
        t = 0;
        while (!(log_q.size() >= 20 && bus.fb_we) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("rst_mid_reached_draw", (t < 2000) ? 1 : 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_fb_we", int'(bus.fb_we), 0);
        chk("rst_mid_pop", int'(bus.pop), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        expect_glyph(e1);
        log_q.delete();
        p0 = pop_cnt;
        do_start();
        wait_done("after_rst", 164);
        chk("after_rst_pops", pop_cnt - p0, 1);
        chk("after_rst_writes", log_q.size(), 128);
        chk("after_rst_exp_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
        $finish;
    end
endmodule

// File: doc/stack_glyph_renderer.md
Name: stack_glyph_renderer

Overview:
- Consumer (pop side) of the character stack buffer.
- On a start pulse it drains the stack entry by entry. For each (character_id, x, y) entry it reads glyph rows from the font ROM and writes the glyph's pixels, one per accepted handshake, into the framebuffer write port.
- Sits between the stack buffer and the framebuffer/VGA memory.
- Pulses done when the stack is empty.

Parameters:
- CHAR_ID_WIDTH, 8, width of character id.
- X_WIDTH, 9, pixel x coordinate width.
- Y_WIDTH, 9, pixel y coordinate width.
- GLYPH_W, 8, glyph width in pixels; also the font ROM data width.
- GLYPH_H, 16, glyph height in rows.
- SCREEN_W, 320, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 240, visible height; pixels with y >= SCREEN_H are clipped.
- FONT_ADDR_WIDTH, 12, font ROM address width; must be >= CHAR_ID_WIDTH + log2(GLYPH_H).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins draining the stack.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when the drain completes.
- pop  out  1  one-cycle pop request to the stack.
- character_id  in  CHAR_ID_WIDTH  top-of-stack id; valid the cycle after pop.
- x  in  X_WIDTH  top-of-stack x; valid the cycle after pop.
- y  in  Y_WIDTH  top-of-stack y; valid the cycle after pop.
- empty  in  1  stack empty flag.
- font_addr  out  FONT_ADDR_WIDTH  character_id*GLYPH_H + row.
- font_data  in  GLYPH_W  glyph row; 1-cycle read latency; MSB = leftmost pixel.
- fb_we  out  1  pixel write valid.
- fb_ready  in  1  framebuffer accepts the write when fb_we && fb_ready.
- fb_x  out  X_WIDTH  pixel x.
- fb_y  out  Y_WIDTH  pixel y.
- fb_data  out  1  glyph bit (1 = foreground, 0 = background).

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE.
  - busy, done, pop, fb_we = 0.
  - font_addr, fb_x, fb_y, fb_data = 0.
  - Internal latches cleared.
  - Reset mid-draw abandons the current glyph immediately. No further pop; entries already popped are lost.
- States: IDLE, POP, LATCH, ROM_REQ, ROM_WAIT, DRAW, DONE.
- IDLE: start=1 goes to DONE if empty=1, otherwise to POP. start while busy is ignored.
- POP: pop=1 for exactly one cycle, then LATCH.
- LATCH: register character_id, x, y; row=0; then ROM_REQ.
- ROM_REQ: drive font_addr = {character_id*GLYPH_H + row}; then ROM_WAIT.
- ROM_WAIT: capture font_data into the row register; col=0; then DRAW.
- DRAW, per column:
  - px = x + col and py = y + row, computed at width+1 bits, so there is no wrap-around.
  - In bounds (px < SCREEN_W and py < SCREEN_H): fb_we=1, fb_x=px, fb_y=py, fb_data = row_bits[GLYPH_W-1-col]. Outputs are held stable until fb_ready=1; col advances on the accepting cycle.
  - Out of bounds: fb_we=0, one cycle, col advances.
  - After col = GLYPH_W-1:
    - row < GLYPH_H-1: row++ and go to ROM_REQ.
    - Last row, empty=0: go to POP.
    - Last row, empty=1: go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
- Throughput with fb_ready tied 1: per character 2 + GLYPH_H*(2+GLYPH_W) cycles, i.e. 162 at defaults.
- Start to done latency:
  - Empty stack: 2 cycles.
  - One character: 1 + 162 + 1 = 164 cycles.
- empty is sampled only in IDLE and at glyph end. Pushes during a drain are consumed if they are present at glyph end.
- Never assert pop while empty=1.

Test Plan:
- Reset then start with empty=1 -> done pulse 2 cycles after start; pop never asserted; fb_we never asserted.
- One entry (id=0x41, x=10, y=20), font ROM row r = 8'hA5, fb_ready=1 -> one pop.
  - First write at (10,20), data 1; second at (11,20), data 0.
  - 128 writes in total; last at (17,35).
  - done 164 cycles after start.
- Three entries pushed in order A, B, C -> glyphs drawn in order C, B, A (LIFO); exactly three pop pulses; done after the third glyph.
- Entry at x=316, y=230 -> only px 316..319 and py 230..239 are written (4*10 = 40 writes); no write has fb_x >= 320 or fb_y >= 240.
- fb_ready toggled 1,0,0,1,... -> fb_x, fb_y, fb_data stay stable while fb_we=1 and fb_ready=0; no pixel is skipped or duplicated (128 accepted writes).
- reset_n low mid-DRAW -> fb_we, pop, busy drop to 0 asynchronously; a new start afterwards pops the next entry normally.
